vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video RAM arbiter sharing one RGB332 frame buffer between the display fetch path and the game-logic writer. Sits between the VGA timing/pixel generator (which issues reads) and the game state logic (which issues writes), driving the synchronous block RAM port. Display reads are hard real-time and have fixed latency. Writes are serviced in free slots through a request/acknowledge handshake.

## Interface
- DEPTH, 19200: number of frame-buffer words (160x120).
- ADDR_W, 15: address width.
- DATA_W, 8: pixel width (Red 3, Green 3, Blue 2).

Ports:
- CLK_100MHz  in  1  sole clock; all logic rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Disp_Req  in  1  display read request, sampled each cycle.
- Disp_Addr  in  ADDR_W  read address, valid with Disp_Req.
- Disp_Data  out  DATA_W  returned pixel, held until next Disp_Valid.
- Disp_Valid  out  1  one-cycle pulse, Disp_Data valid.
- Blank  in  1  high during H or V blanking, from the timing generator.
- Wr_Req  in  1  write request, level, held until Wr_Ack.
- Wr_Addr  in  ADDR_W  write address, stable while Wr_Req.
- Wr_Data  in  DATA_W  write pixel, stable while Wr_Req.
- Wr_Ack  out  1  one-cycle pulse, write committed or dropped.
- Ram_En  out  1  RAM port enable.
- Ram_We  out  1  RAM write enable.
- Ram_Addr  out  ADDR_W  RAM address.
- Ram_Wdata  out  DATA_W  RAM write data.
- Ram_Rdata  in  DATA_W  RAM read data, valid 1 cycle after Ram_En with Ram_We=0.

## Operation
- The issue register holds one of three states per cycle: IDLE, RD, WR. All Ram_* outputs are registered from it.
- Selection in cycle N takes effect in N+1:
  - Disp_Req=1 selects RD.
  - Otherwise, a write is eligible when Wr_Req=1 and Wr_Ack is not high in N. The eligible write selects WR.
  - Otherwise the register selects IDLE.
- Display always wins. With Disp_Req and Wr_Req both high, the read is issued and the write waits.
- With Disp_Req high every cycle, the writer stalls indefinitely. Display duty is the caller's responsibility; the timing generator issues at most one read per 4 cycles.
- A write is issued at most once per Wr_Req assertion. It is never re-issued in the cycle Wr_Ack is high.
- Out-of-range read (Disp_Addr >= DEPTH):
  - No RAM access; Ram_En stays 0 for that slot.
  - Disp_Data=0 (black), with Disp_Valid on the normal schedule.
- Out-of-range write (Wr_Addr >= DEPTH):
  - Ram_En and Ram_We stay 0.
  - Wr_Ack still pulses, and the write is dropped.
- Address compare is unsigned, full ADDR_W.
- Reset mid-operation:
  - In-flight reads are discarded; no Disp_Valid is produced for them.
  - A pending write is not acked; the requester re-issues it.

## Timing
- Reset values: Ram_En=0, Ram_We=0, Ram_Addr=0, Ram_Wdata=0, Disp_Data=0, Disp_Valid=0, Wr_Ack=0, issue=IDLE.
- Read, with Disp_Req sampled at N:
  - N+1: Ram_En=1, Ram_We=0, Ram_Addr=Disp_Addr.
  - N+2: Ram_Rdata valid.
  - N+3: Disp_Valid=1 and Disp_Data registered.
  - Latency is exactly 3 cycles. Reads are fully pipelined, one per cycle.
- Write, granted at N:
  - N+1: Ram_En=1, Ram_We=1, Ram_Addr=Wr_Addr, Ram_Wdata=Wr_Data, Wr_Ack=1.
  - The requester may drop Wr_Req or present the next write at N+2. The earliest next grant is N+2, taking effect at N+3.
- Idle cycles: Ram_En=0, Ram_We=0. Ram_Addr and Ram_Wdata hold their last values.

## Configuration
- VRAM_BLANK_WRITE_EN defined:
  - Writes are eligible only when Blank=1 in the selection cycle, giving tear-free updates.
  - A write requested during active video waits, with Wr_Ack delayed, until blanking.
- VRAM_BLANK_WRITE_EN undefined: Blank is ignored, and writes use any cycle without Disp_Req.

## Structure
- Package vram_arb_pkg holds:
  - the DEPTH, ADDR_W and DATA_W defaults;
  - the issue-state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2).
- One sub-module, vram_rd_pipe: a 2-stage valid/out-of-range pipeline that registers Ram_Rdata into Disp_Data and produces Disp_Valid. The issue logic stays in vram_arbiter.

## Test plan
- Single read: RAM[0x0010]=0xE3, Disp_Req pulse with Disp_Addr=0x0010 at N -> Ram_En=1, Ram_Addr=0x0010 at N+1; Disp_Valid=1, Disp_Data=0xE3 at N+3.
- Collision: Disp_Req and Wr_Req(0x0020, 0x1C) in the same cycle -> read issued first; Wr_Ack the following cycle; RAM[0x0020]=0x1C.
- Out of range: Disp_Addr=19200 -> Ram_En=0, Disp_Data=0x00 with Disp_Valid at N+3. Wr_Addr=19201 -> Wr_Ack pulses, Ram_We never 1.
- Back-to-back writes: Wr_Req held across two writes -> exactly one Ram_We per Wr_Ack, with grants no closer than 2 cycles.
- Reset mid-read: Reset_n low at N+1 after Disp_Req -> all outputs 0 immediately; no Disp_Valid follows release.
- With VRAM_BLANK_WRITE_EN: Wr_Req while Blank=0 for 50 cycles -> no Wr_Ack; Blank rises -> Wr_Ack within 2 cycles.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared sizes and issue-state encoding for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned DEPTH  = 19200;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } issue_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read return path: carries valid/out-of-range alongside the RAM latency and
// registers the returned pixel.
module vram_rd_pipe #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue,
  input  logic              rd_oor,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  logic valid_q;
  logic oor_q;

  // Stage aligned with the RAM's read-data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      valid_q <= rd_issue;
      oor_q   <= rd_oor;
    end
  end

  // Out-of-range reads return black; data holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      disp_valid <= valid_q;
      if (valid_q) begin
        disp_data <= oor_q ? '0 : ram_rdata;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, writes fill free slots.
// Optional VRAM_BLANK_WRITE_EN restricts writes to blanking intervals.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = vram_arb_pkg::DEPTH,
  parameter int unsigned ADDR_W = vram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = vram_arb_pkg::DATA_W
) (
  input  logic              CLK_100MHz,
  input  logic              Reset_n,
  input  logic              Disp_Req,
  input  logic [ADDR_W-1:0] Disp_Addr,
  output logic [DATA_W-1:0] Disp_Data,
  output logic              Disp_Valid,
  input  logic              Blank,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ack,
  output logic              Ram_En,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Wdata,
  input  logic [DATA_W-1:0] Ram_Rdata
);

  issue_e issue;
  issue_e sel_c;
  logic   rd_oor;
  logic   disp_oor_c;
  logic   wr_oor_c;
  logic   blank_ok_c;

`ifdef VRAM_BLANK_WRITE_EN
  assign blank_ok_c = Blank;
`else
  // Blank is accepted but has no effect in this build.
  assign blank_ok_c = Blank | 1'b1;
`endif

  assign disp_oor_c = Disp_Addr >= ADDR_W'(DEPTH);
  assign wr_oor_c   = Wr_Addr >= ADDR_W'(DEPTH);

  // Selection; Wr_Ack high blocks re-issuing the write being acknowledged.
  always_comb begin
    sel_c = IDLE;
    if (Disp_Req) begin
      sel_c = RD;
    end else if (Wr_Req && !Wr_Ack && blank_ok_c) begin
      sel_c = WR;
    end
  end

  // Issue register and registered RAM port; address/data hold when idle.
  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      issue     <= IDLE;
      rd_oor    <= 1'b0;
      Ram_En    <= 1'b0;
      Ram_We    <= 1'b0;
      Ram_Addr  <= '0;
      Ram_Wdata <= '0;
      Wr_Ack    <= 1'b0;
    end else begin
      issue  <= sel_c;
      rd_oor <= 1'b0;
      Ram_En <= 1'b0;
      Ram_We <= 1'b0;
      Wr_Ack <= 1'b0;
      case (sel_c)
        RD: begin
          rd_oor <= disp_oor_c;
          if (!disp_oor_c) begin
            Ram_En   <= 1'b1;
            Ram_Addr <= Disp_Addr;
          end
        end
        WR: begin
          Wr_Ack <= 1'b1;
          if (!wr_oor_c) begin
            Ram_En    <= 1'b1;
            Ram_We    <= 1'b1;
            Ram_Addr  <= Wr_Addr;
            Ram_Wdata <= Wr_Data;
          end
        end
        default: ;
      endcase
    end
  end

  vram_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk        (CLK_100MHz),
    .rst_n      (Reset_n),
    .rd_issue   (issue == RD),
    .rd_oor     (rd_oor),
    .ram_rdata  (Ram_Rdata),
    .disp_data  (Disp_Data),
    .disp_valid (Disp_Valid)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        blank;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:32767];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .CLK_100MHz (clk),
    .Reset_n    (rst_n),
    .Disp_Req   (disp_req),
    .Disp_Addr  (disp_addr),
    .Disp_Data  (disp_data),
    .Disp_Valid (disp_valid),
    .Blank      (blank),
    .Wr_Req     (wr_req),
    .Wr_Addr    (wr_addr),
    .Wr_Data    (wr_data),
    .Wr_Ack     (wr_ack),
    .Ram_En     (ram_en),
    .Ram_We     (ram_we),
    .Ram_Addr   (ram_addr),
    .Ram_Wdata  (ram_wdata),
    .Ram_Rdata  (ram_rdata)
  );

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    string       name;
    logic [14:0] addr;
    logic        exp_en;
    logic [7:0]  exp_data;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string name, input logic [14:0] addr,
                         input logic exp_en, input logic [7:0] exp_data);
    disp_req  = 1'b1;
    disp_addr = addr;
    step();
    chk({name, " ram_en"}, 32'(ram_en), 32'(exp_en));
    chk({name, " ram_we"}, 32'(ram_we), 32'd0);
    if (exp_en) chk({name, " ram_addr"}, 32'(ram_addr), 32'(addr));
    chk({name, " valid early"}, 32'(disp_valid), 32'd0);
    disp_req = 1'b0;
    step();
    chk({name, " valid n+2"}, 32'(disp_valid), 32'd0);
    step();
    chk({name, " valid n+3"}, 32'(disp_valid), 32'd1);
    chk({name, " data"}, 32'(disp_data), 32'(exp_data));
    step();
    chk({name, " valid pulse"}, 32'(disp_valid), 32'd0);
    chk({name, " data hold"}, 32'(disp_data), 32'(exp_data));
  endtask

  initial begin
    int acks;
    int wes;
    int ack_cyc [2];
    int valids;
    int got;

    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[15'h0000] = 8'h5A;
    mem[15'h0010] = 8'hE3;
    mem[15'd19199] = 8'h81;
    mem[15'd19200] = 8'hAA;
    mem[15'h7FFF] = 8'hBB;

    vecs[0] = '{"rd_0010", 15'h0010, 1'b1, 8'hE3};
    vecs[1] = '{"rd_0000", 15'h0000, 1'b1, 8'h5A};
    vecs[2] = '{"rd_last", 15'd19199, 1'b1, 8'h81};
    vecs[3] = '{"rd_oor_depth", 15'd19200, 1'b0, 8'h00};
    vecs[4] = '{"rd_after_oor", 15'h0010, 1'b1, 8'hE3};
    vecs[5] = '{"rd_oor_max", 15'h7FFF, 1'b0, 8'h00};

    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0; blank = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst ram_en", 32'(ram_en), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst disp_valid", 32'(disp_valid), 32'd0);
    chk("rst disp_data", 32'(disp_data), 32'd0);
    chk("rst wr_ack", 32'(wr_ack), 32'd0);

    foreach (vecs[i]) do_read(vecs[i].name, vecs[i].addr, vecs[i].exp_en, vecs[i].exp_data);

    // Fully pipelined reads on consecutive cycles.
    disp_req = 1'b1; disp_addr = 15'h0000; step();
    disp_addr = 15'h0010; step();
    disp_addr = 15'd19199; step();
    disp_req = 1'b0;
    chk("pipe v0", 32'({disp_valid, disp_data}), 32'h15A);
    step();
    chk("pipe v1", 32'({disp_valid, disp_data}), 32'h1E3);
    step();
    chk("pipe v2", 32'({disp_valid, disp_data}), 32'h181);
    step();
    chk("pipe end", 32'(disp_valid), 32'd0);

    // Collision: read wins, write follows.
    disp_req = 1'b1; disp_addr = 15'h0010;
    wr_req = 1'b1; wr_addr = 15'h0020; wr_data = 8'h1C;
    step();
    chk("col read first en", 32'({ram_en, ram_we}), 32'b10);
    chk("col read addr", 32'(ram_addr), 32'h0010);
    chk("col no ack yet", 32'(wr_ack), 32'd0);
    disp_req = 1'b0;
    step();
    chk("col write ack", 32'(wr_ack), 32'd1);
    chk("col write en/we", 32'({ram_en, ram_we}), 32'b11);
    chk("col write addr", 32'(ram_addr), 32'h0020);
    chk("col write data", 32'(ram_wdata), 32'h1C);
    wr_req = 1'b0;
    step();
    chk("col ack pulse", 32'(wr_ack), 32'd0);
    chk("idle en/we", 32'({ram_en, ram_we}), 32'b00);
    chk("idle addr hold", 32'(ram_addr), 32'h0020);
    chk("idle wdata hold", 32'(ram_wdata), 32'h1C);
    chk("col mem", 32'(mem[15'h0020]), 32'h1C);
    do_read("rd_back_0020", 15'h0020, 1'b1, 8'h1C);

    // Out-of-range write is acked but never reaches the RAM.
    wr_req = 1'b1; wr_addr = 15'd19201; wr_data = 8'h77;
    acks = 0; wes = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ram_we) wes++;
      if (wr_ack) begin
        acks++;
        wr_req = 1'b0;
      end
    end
    chk("oor wr ack", 32'(acks), 32'd1);
    chk("oor wr no we", 32'(wes), 32'd0);
    chk("oor wr mem", 32'(mem[15'd19201]), 32'h00);

    // Back-to-back writes with Wr_Req held.
    wr_req = 1'b1; wr_addr = 15'h0030; wr_data = 8'h11;
    acks = 0; wes = 0; ack_cyc[0] = 0; ack_cyc[1] = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ram_we) wes++;
      if (wr_ack) begin
        if (acks < 2) ack_cyc[acks] = c;
        acks++;
        if (acks == 1) begin
          wr_addr = 15'h0031; wr_data = 8'h22;
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    chk("b2b acks", 32'(acks), 32'd2);
    chk("b2b we count", 32'(wes), 32'd2);
    chk("b2b ack gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
    chk("b2b mem0", 32'(mem[15'h0030]), 32'h11);
    chk("b2b mem1", 32'(mem[15'h0031]), 32'h22);

    // Reset during an in-flight read.
    disp_req = 1'b1; disp_addr = 15'h0010;
    step();
    disp_req = 1'b0;
    chk("rstmid en before", 32'(ram_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid ram_en", 32'(ram_en), 32'd0);
    chk("rstmid ram_addr", 32'(ram_addr), 32'd0);
    chk("rstmid ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rstmid disp_data", 32'(disp_data), 32'd0);
    chk("rstmid valid/ack/we", 32'({disp_valid, wr_ack, ram_we}), 32'd0);
    step();
    rst_n = 1'b1;
    valids = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (disp_valid) valids++;
    end
    chk("rstmid no valid", 32'(valids), 32'd0);

`ifdef VRAM_BLANK_WRITE_EN
    // Writes wait for blanking.
    blank = 1'b0;
    wr_req = 1'b1; wr_addr = 15'h0040; wr_data = 8'h55;
    acks = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (wr_ack) acks++;
    end
    chk("blank hold no ack", 32'(acks), 32'd0);
    blank = 1'b1;
    got = 0;
    for (int c = 0; c < 2 && got == 0; c++) begin
      step();
      if (wr_ack) got = 1;
    end
    wr_req = 1'b0;
    chk("blank release ack", 32'(got), 32'd1);
`else
    // Blank is ignored: write proceeds during active video.
    blank = 1'b0;
    wr_req = 1'b1; wr_addr = 15'h0040; wr_data = 8'h55;
    got = 0;
    for (int c = 0; c < 2 && got == 0; c++) begin
      step();
      if (wr_ack) got = 1;
    end
    wr_req = 1'b0;
    chk("active video ack", 32'(got), 32'd1);
    blank = 1'b1;
`endif
    step();
    chk("blank test mem", 32'(mem[15'h0040]), 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
